// File: rtl/dcache_port_arbiter.sv
// Two-port arbiter in front of the single D$ request port (0 = MEM stage, 1 = PTW).
// Define DCARB_STARVE_GUARD_EN to force a port-1 win after STARVE_LIMIT lost arbitrations.
module dcache_port_arbiter #(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  r0_en,
    input  logic                  r0_lock,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic                  r0_write_en,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    input  logic [1:0]            r0_wlen,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    output logic                  r0_rvalid,
    output logic                  r0_write_done,
    output logic                  r0_grant,

    input  logic                  r1_en,
    input  logic                  r1_lock,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic                  r1_write_en,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    input  logic [1:0]            r1_wlen,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  r1_rvalid,
    output logic                  r1_write_done,
    output logic                  r1_grant,

    output logic                  dc_en,
    output logic [ADDR_WIDTH-1:0] dc_in_addr,
    output logic                  dc_write_en,
    output logic [DATA_WIDTH-1:0] dc_in_wdata,
    output logic [1:0]            dc_in_wlen,
    input  logic [DATA_WIDTH-1:0] dc_out_rdata,
    input  logic                  dc_out_rvalid,
    input  logic                  dc_out_write_done
);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

    state_e state_q;
    logic   owner_q;

    logic own_en;
    logic own_lock;
    logic own_we;
    logic busy;
    logic hold;
    logic done;
    logic win1;

    assign own_en   = owner_q ? r1_en       : r0_en;
    assign own_lock = owner_q ? r1_lock     : r0_lock;
    assign own_we   = owner_q ? r1_write_en : r0_write_en;

    assign busy = (state_q == BUSY);
    assign hold = (state_q == HOLD);

    // A strobe of the wrong kind for the owner's direction is not a completion.
    assign done = busy & (own_we ? dc_out_write_done : dc_out_rvalid);

`ifdef DCARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_q;
    logic [CW-1:0] starve_d;
    logic          starve_hit;

    assign starve_hit = (starve_q == CW'(STARVE_LIMIT));
    assign win1       = r1_en & (~r0_en | starve_hit);

    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (r0_en & r1_en & ~starve_hit)
                starve_d = starve_q + CW'(1);
            else
                starve_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            starve_q <= '0;
        else
            starve_q <= starve_d;
    end
`else
    assign win1 = r1_en & ~r0_en;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (r0_en | r1_en) begin
                        owner_q <= win1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (done)
                        state_q <= own_lock ? HOLD : IDLE;
                    else if (!own_en)
                        state_q <= IDLE;
                end
                HOLD: begin
                    if (!own_lock)
                        state_q <= IDLE;
                    else if (own_en)
                        state_q <= BUSY;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dc_en       = busy & own_en;
    assign dc_in_addr  = owner_q ? r1_addr  : r0_addr;
    assign dc_write_en = own_we;
    assign dc_in_wdata = owner_q ? r1_wdata : r0_wdata;
    assign dc_in_wlen  = owner_q ? r1_wlen  : r0_wlen;

    assign r0_grant = (busy | hold) & ~owner_q;
    assign r1_grant = (busy | hold) &  owner_q;

    assign r0_rvalid     = busy & ~owner_q & ~own_we & dc_out_rvalid;
    assign r1_rvalid     = busy &  owner_q & ~own_we & dc_out_rvalid;
    assign r0_write_done = busy & ~owner_q &  own_we & dc_out_write_done;
    assign r1_write_done = busy &  owner_q &  own_we & dc_out_write_done;

    assign r0_rdata = dc_out_rdata;
    assign r1_rdata = dc_out_rdata;

    a_cfg_limit: assert property (@(posedge clk) STARVE_LIMIT >= 1);

    a_owner_holds_en: assert property (
        @(posedge clk) disable iff (reset) busy |-> (own_en | done));

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: directed vector table, corner sequences,
// and random traffic against a transaction-level ownership model.
module tb_dcache_port_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SL = 2;
`ifdef DCARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    logic          e [2];
    logic          l [2];
    logic          w [2];
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    logic [1:0]    n [2];

    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          r0_rvalid, r1_rvalid;
    logic          r0_write_done, r1_write_done;
    logic          r0_grant, r1_grant;
    logic          dc_en, dc_write_en;
    logic [AW-1:0] dc_in_addr;
    logic [DW-1:0] dc_in_wdata;
    logic [1:0]    dc_in_wlen;
    logic [DW-1:0] dc_rd;
    logic          dc_rv, dc_wd;

    dcache_port_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .r0_en            (e[0]),
        .r0_lock          (l[0]),
        .r0_addr          (a[0]),
        .r0_write_en      (w[0]),
        .r0_wdata         (d[0]),
        .r0_wlen          (n[0]),
        .r0_rdata         (r0_rdata),
        .r0_rvalid        (r0_rvalid),
        .r0_write_done    (r0_write_done),
        .r0_grant         (r0_grant),
        .r1_en            (e[1]),
        .r1_lock          (l[1]),
        .r1_addr          (a[1]),
        .r1_write_en      (w[1]),
        .r1_wdata         (d[1]),
        .r1_wlen          (n[1]),
        .r1_rdata         (r1_rdata),
        .r1_rvalid        (r1_rvalid),
        .r1_write_done    (r1_write_done),
        .r1_grant         (r1_grant),
        .dc_en            (dc_en),
        .dc_in_addr       (dc_in_addr),
        .dc_write_en      (dc_write_en),
        .dc_in_wdata      (dc_in_wdata),
        .dc_in_wlen       (dc_in_wlen),
        .dc_out_rdata     (dc_rd),
        .dc_out_rvalid    (dc_rv),
        .dc_out_write_done(dc_wd)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // inputs: e0 l0 w0 e1 w1 rv wd ; x: dc_en g0 g1 rv0 rv1 wd0 wd1
    typedef struct packed {
        logic [6:0] in;
        logic [6:0] x;
    } vec_t;

    vec_t tbl [22];

    task automatic check(input string nm, input logic [199:0] act,
                         input logic [199:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] obs();
        return {dc_en, r0_grant, r1_grant, r0_rvalid, r1_rvalid,
                r0_write_done, r1_write_done};
    endfunction

    function automatic logic [130:0] mux_act();
        return {dc_write_en, dc_in_wlen, dc_in_addr, dc_in_wdata};
    endfunction

    function automatic logic [130:0] mux_exp(input int p);
        return {w[p], n[p], a[p], d[p]};
    endfunction

    task automatic all_idle();
        for (int p = 0; p < 2; p++) begin
            e[p] = 1'b0;
            l[p] = 1'b0;
            w[p] = 1'b0;
        end
        dc_rv = 1'b0;
        dc_wd = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        all_idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // model state: who owns the port, whether its access is outstanding,
    // and how many arbitrations port 1 has lost in a row
    int own;
    bit outst;
    int lost;
    bit comp_last [2];

    int first1;
    int arb;
    bit prev_g;

    initial begin
        tbl[0]  = {7'b1000000, 7'b0000000};
        tbl[1]  = {7'b1000000, 7'b1100000};
        tbl[2]  = {7'b1000000, 7'b1100000};
        tbl[3]  = {7'b1000010, 7'b1101000};
        tbl[4]  = {7'b0000000, 7'b0000000};
        tbl[5]  = {7'b1011100, 7'b0000000};
        tbl[6]  = {7'b1011100, 7'b1100000};
        tbl[7]  = {7'b1011101, 7'b1100010};
        tbl[8]  = {7'b0001100, 7'b0000000};
        tbl[9]  = {7'b0001110, 7'b1010000};
        tbl[10] = {7'b0001101, 7'b1010001};
        tbl[11] = {7'b0000000, 7'b0000000};
        tbl[12] = {7'b1101000, 7'b0000000};
        tbl[13] = {7'b1101000, 7'b1100000};
        tbl[14] = {7'b1101010, 7'b1101000};
        tbl[15] = {7'b1111000, 7'b0100000};
        tbl[16] = {7'b1111000, 7'b1100000};
        tbl[17] = {7'b1111001, 7'b1100010};
        tbl[18] = {7'b0001000, 7'b0100000};
        tbl[19] = {7'b0001000, 7'b0000000};
        tbl[20] = {7'b0001010, 7'b1010100};
        tbl[21] = {7'b0000000, 7'b0000000};

        all_idle();
        a[0]  = 64'h1000;
        a[1]  = 64'h2000;
        d[0]  = 64'h0101_0101_0101_0101;
        d[1]  = 64'h0202_0202_0202_0202;
        n[0]  = 2'd3;
        n[1]  = 2'd2;
        dc_rd = 64'hDEAD_BEEF;

        // reset held with both ports requesting: nothing may be granted
        reset = 1'b1;
        e[0]  = 1'b1;
        e[1]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("in_reset", 200'(obs()), 200'(0));

        for (int i = 0; i < 22; i++) begin
            @(posedge clk);
            #1;
            reset = 1'b0;
            {e[0], l[0], w[0], e[1], w[1], dc_rv, dc_wd} = tbl[i].in;
            @(negedge clk);
            check($sformatf("vec%0d", i), 200'(obs()), 200'(tbl[i].x));
            if (tbl[i].x[6])
                check($sformatf("vec%0d_mux", i), 200'(mux_act()),
                      200'(mux_exp(tbl[i].x[4] ? 1 : 0)));
            if (tbl[i].x[3])
                check($sformatf("vec%0d_rdata", i), 200'(r0_rdata),
                      200'(64'hDEAD_BEEF));
        end

        // reset while an access is on the D$ port, late rvalid afterwards
        @(posedge clk);
        #1;
        all_idle();
        e[0] = 1'b1;
        @(posedge clk);
        #1;
        check("rst_pre_busy", 200'(dc_en), 200'(1));
        reset = 1'b1;
        e[0]  = 1'b0;
        #1;
        check("rst_async", 200'(obs()), 200'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        dc_rv = 1'b1;
        @(negedge clk);
        check("rst_late_rvalid", 200'(obs()), 200'(0));
        @(posedge clk);
        #1;
        dc_rv = 1'b0;

        // starvation: port 0 reissues back-to-back, port 1 waits
        do_reset();
        e[0]   = 1'b1;
        e[1]   = 1'b1;
        first1 = 0;
        arb    = 0;
        prev_g = 1'b0;
        for (int c = 0; c < 60 && first1 == 0 && arb < 7; c++) begin
            @(negedge clk);
            dc_rv = dc_en;
            if ((r0_grant | r1_grant) && !prev_g) begin
                arb++;
                if (r1_grant)
                    first1 = arb;
            end
            prev_g = r0_grant | r1_grant;
        end
        check("starve_first_p1_arb", 200'(first1), 200'(GUARD ? 3 : 0));
        @(posedge clk);
        #1;
        all_idle();

        // random traffic against the ownership model
        do_reset();
        own   = -1;
        outst = 1'b0;
        lost  = 0;
        comp_last[0] = 1'b0;
        comp_last[1] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (comp_last[p] || !e[p]) begin
                    if (comp_last[p] || !l[p] || $urandom_range(2) == 0)
                        l[p] = l[p] && comp_last[p] && ($urandom_range(1) == 0);
                    if ($urandom_range(3) == 0) begin
                        e[p] = 1'b1;
                        w[p] = $urandom_range(1) == 1;
                        l[p] = $urandom_range(3) == 0;
                        a[p] = {$urandom, $urandom};
                        d[p] = {$urandom, $urandom};
                        n[p] = 2'($urandom_range(3));
                    end else begin
                        e[p] = 1'b0;
                    end
                end
            end
            dc_rv = $urandom_range(2) == 0;
            dc_wd = $urandom_range(2) == 0;
            dc_rd = {$urandom, $urandom};

            @(negedge clk);
            begin
                int  o;
                bit  de, comp, win;
                o    = own;
                de   = (o >= 0) && outst && e[o < 0 ? 0 : o];
                comp = (o >= 0) && outst &&
                       (w[o < 0 ? 0 : o] ? dc_wd : dc_rv);
                check($sformatf("rand%0d", c), 200'(obs()),
                      200'({de, o == 0, o == 1,
                            comp && o == 0 && !w[0], comp && o == 1 && !w[1],
                            comp && o == 0 && w[0],  comp && o == 1 && w[1]}));
                if (de)
                    check($sformatf("rand%0d_mux", c), 200'(mux_act()),
                          200'(mux_exp(o)));
                if (c % 50 == 0)
                    check($sformatf("rand%0d_rdata", c),
                          200'({r0_rdata, r1_rdata}), 200'({dc_rd, dc_rd}));
                comp_last[0] = comp && o == 0;
                comp_last[1] = comp && o == 1;
                if (o < 0) begin
                    if (e[0] || e[1]) begin
                        win  = e[1] && (!e[0] || (GUARD && lost == SL));
                        lost = (e[0] && e[1] && !win) ?
                               ((lost + 1 > SL) ? SL : lost + 1) : 0;
                        own   = win ? 1 : 0;
                        outst = 1'b1;
                    end else begin
                        lost = 0;
                    end
                end else if (outst) begin
                    if (comp) begin
                        if (l[o]) outst = 1'b0;
                        else      own = -1;
                    end else if (!e[o]) begin
                        own = -1;
                    end
                end else begin
                    if (!l[o])     own = -1;
                    else if (e[o]) outst = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares the single D$ request port between two requesters: port 0 is the MEM stage load/store/atomic path, port 1 is the page-table walker.
- Sequences one transaction at a time and routes each completion only to its owner.
- Holds ownership across multi-access atomic read-modify-write sequences.
- Sits between the MEM stage / walker and the D$ controller.

Parameters:
ADDR_WIDTH, 64, request address width
DATA_WIDTH, 64, read/write data width
STARVE_LIMIT, 8, consecutive lost arbitrations by port 1 before it is forced to win (min 1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
rN_en  in  1  port N request valid; level; held stable until completion (N = 0,1; one port per N)
rN_lock  in  1  port N keeps ownership after completion (atomic RMW)
rN_addr  in  ADDR_WIDTH  port N byte address
rN_write_en  in  1  port N: 1 = write, 0 = read
rN_wdata  in  DATA_WIDTH  port N write data
rN_wlen  in  2  port N log2(bytes) of write
rN_rdata  out  DATA_WIDTH  copy of dc_out_rdata
rN_rvalid  out  1  read completion for port N
rN_write_done  out  1  write completion for port N
rN_grant  out  1  port N currently owns the D$ port
dc_en  out  1  request to D$
dc_in_addr  out  ADDR_WIDTH  muxed address
dc_write_en  out  1  muxed write enable
dc_in_wdata  out  DATA_WIDTH  muxed write data
dc_in_wlen  out  2  muxed write length
dc_out_rdata  in  DATA_WIDTH  D$ read data
dc_out_rvalid  in  1  D$ read complete
dc_out_write_done  in  1  D$ write complete

Behaviour:
- Registered state: state {IDLE, BUSY, HOLD}, owner (1 bit), starve_cnt (clog2(STARVE_LIMIT+1) bits).
- Reset (asynchronous): state=IDLE, owner=0, starve_cnt=0.
  - While reset is asserted and in the first cycle after it: dc_en=0, rN_grant=0, rN_rvalid=0, rN_write_done=0.
  - A reset mid-transaction abandons the transaction; a late D$ completion arriving in IDLE is dropped.
- IDLE: dc_en=0, no grants asserted. Arbitration when any rN_en is high:
  - Only one requester: it wins.
  - Both requesting: port 0 wins unless starve_cnt==STARVE_LIMIT, in which case port 1 wins.
  - Next edge: owner=winner, state=BUSY.
  - starve_cnt: +1 (saturating) when port 1 loses while requesting; 0 when port 1 wins or r1_en is low.
- Arbitration latency: exactly one cycle from rN_en to dc_en.
- BUSY:
  - dc_en = rowner_en. dc_in_* and dc_write_en = owner's inputs (combinational mux). rowner_grant=1.
  - Completion means (dc_out_rvalid & !owner_write_en) or (dc_out_write_done & owner_write_en).
  - rowner_rvalid / rowner_write_done mirror the D$ strobe in the same cycle (0 added latency). The non-owner never sees a strobe.
  - On completion: rowner_lock=1 -> HOLD; else -> IDLE.
  - Owner dropping en before completion is a protocol error: assertion fires, state -> IDLE.
- HOLD: ownership retained, dc_en=0, rowner_grant=1, the other port is blocked.
  - rowner_lock=0 -> IDLE.
  - Else rowner_en=1 -> BUSY next cycle (new access; one bubble between the accesses of an atomic).
- Requester contract: rN_en must drop in the cycle after completion unless a new access is intended.
- Simultaneous completion and reset: reset wins. A completion strobe that is the wrong kind for the owner's direction is ignored.
- rN_rdata = dc_out_rdata for both ports, unqualified.

Optional Feature:
DCARB_STARVE_GUARD_EN
- Defined: starvation counter and forced port-1 win as described above.
- Not defined: starve_cnt is removed, STARVE_LIMIT is ignored, and port 0 has strict fixed priority.

Test Plan:
- Single read: r0_en=1, addr=0x1000, write_en=0; D$ returns rvalid with data 0xDEAD_BEEF two cycles after dc_en -> dc_en rises 1 cycle after r0_en, r0_rvalid=1 with r0_rdata=0xDEAD_BEEF in that same cycle, r1_rvalid stays 0, state back to IDLE.
- Contention: r0_en and r1_en rise together, each a write -> port 0 served first (r0_write_done), then port 1 after r0_en drops; dc_in_addr tracks the owner.
- Atomic lock: r0 read with r0_lock=1, then write to the same addr, while r1_en is high throughout -> r1_grant=0 until r0_lock drops; exactly two D$ accesses for port 0, with dc_en=0 for one cycle between them.
- Starvation (macro on, STARVE_LIMIT=2): r0_en held high and issuing back-to-back reads, r1_en held high -> port 1 granted on the 3rd arbitration; with macro off, port 1 is never granted.
- Reset mid-BUSY: assert reset while dc_en=1, then give dc_out_rvalid after deassertion -> all outputs 0 immediately, and the late rvalid produces no rN_rvalid.
